// File: rtl/trace_collector.sv
// Multi-source debug trace collector: per-source pending registers,
// arbitration into a circular trace buffer, and a registered read port.
module trace_collector #(
  parameter int    N_SRC    = 5,
  parameter int    TRw      = 32,
  parameter int    TSw      = 16,
  parameter int    TB_DEPTH = 512,
  parameter string ARB_TYPE = "RRA",
  parameter string BUF_MODE = "STOP",
  localparam int   SRCw     = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int   EW       = SRCw + TSw + TRw,
  localparam int   AW       = $clog2(TB_DEPTH),
  localparam int   CNTw     = AW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SRC*TRw-1:0] trace_in,
  input  logic [N_SRC-1:0]   trigger_in,
  input  logic [N_SRC-1:0]   src_en,
  input  logic               arm,
  input  logic               stop,
  input  logic               rd,
  output logic [EW-1:0]      dout,
  output logic               dout_valid,
  output logic               empty,
  output logic               full,
  output logic [CNTw-1:0]    count,
  output logic [1:0]         state,
  output logic [N_SRC*8-1:0] drop_cnt_all,
  output logic               overflow
);

  localparam bit WRAP  = (BUF_MODE == "WRAP");
  localparam bit FIXED = (ARB_TYPE == "FIXED");

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [TSw-1:0]   ts_q;
  logic [N_SRC-1:0] pend_v_q;
  logic [TSw-1:0]   pend_ts_q [N_SRC];
  logic [TRw-1:0]   pend_tr_q [N_SRC];
  logic [7:0]       drop_q [N_SRC];
  logic [SRCw-1:0]  last_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTw-1:0]  count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [EW-1:0]    dout_q;
  logic             dval_q;
  logic [EW-1:0]    mem [TB_DEPTH];

  logic             run, clr_run, clr_done;
  logic             pop, can_wr, ovw;
  logic [N_SRC-1:0] req, gnt;
  logic             gnt_vld;
  logic [SRCw-1:0]  gnt_idx;
  logic [EW-1:0]    wr_data;
  logic             full_w;

  assign run      = (state_q == S_RUN);
  assign clr_run  = arm & ~run;
  assign clr_done = run & stop;
  assign full_w   = (count_q == CNTw'(TB_DEPTH));
  assign pop      = rd & (count_q != '0);
  assign can_wr   = run & (~full_w | pop | WRAP);
  assign req      = trigger_in & src_en & {N_SRC{run}};
  assign ovw      = gnt_vld & full_w & ~pop;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (arm)  state_d = S_RUN;
      S_RUN:          if (stop) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // RRA searches from the source after the last grant; FIXED from 0
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    wr_data = '0;
    if (can_wr) begin
      for (int k = 0; k < N_SRC; k++) begin
        idx = FIXED ? k : (int'(last_q) + 1 + k) % N_SRC;
        if (!gnt_vld && pend_v_q[idx]) begin
          gnt_vld  = 1'b1;
          gnt_idx  = SRCw'(idx);
          gnt[idx] = 1'b1;
          wr_data  = {SRCw'(idx), pend_ts_q[idx], pend_tr_q[idx]};
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | ovw;
    if (gnt_vld) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop | ovw) rd_ptr_d = rd_ptr_q + 1'b1;
    if (gnt_vld && !pop && !full_w) count_d = count_q + 1'b1;
    else if (pop && !gnt_vld)       count_d = count_q - 1'b1;
    if (clr_run) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ts_q     <= '0;
      last_q   <= SRCw'(N_SRC - 1);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      dout_q   <= '0;
      dval_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ts_q     <= ts_q + 1'b1;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      dval_q   <= pop;
      if (gnt_vld) last_q <= gnt_idx;
      if (pop) dout_q <= mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_v_q <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        pend_ts_q[i] <= '0;
        pend_tr_q[i] <= '0;
        drop_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (clr_run || clr_done) begin
          pend_v_q[i] <= 1'b0;
        end else if (req[i] && (!pend_v_q[i] || gnt[i])) begin
          pend_v_q[i]  <= 1'b1;
          pend_ts_q[i] <= ts_q;
          pend_tr_q[i] <= trace_in[i*TRw +: TRw];
        end else if (gnt[i]) begin
          pend_v_q[i] <= 1'b0;
        end
        if (clr_run)
          drop_q[i] <= '0;
        else if (req[i] && pend_v_q[i] && !gnt[i] && drop_q[i] != 8'hFF)
          drop_q[i] <= drop_q[i] + 1'b1;
      end
    end
  end

  // Buffer RAM has no reset; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (gnt_vld) mem[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    for (int i = 0; i < N_SRC; i++) drop_cnt_all[i*8 +: 8] = drop_q[i];
  end

  assign dout       = dout_q;
  assign dout_valid = dval_q;
  assign empty      = (count_q == '0);
  assign full       = full_w;
  assign count      = count_q;
  assign state      = state_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_trace_collector.sv
// Directed bench: FIXED/STOP and RRA/WRAP collectors on shared stimulus.
module tb_trace_collector;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [159:0] trace_in = '0;
  logic [4:0]   trigger_in = '0;
  logic [4:0]   src_en = 5'b11111;
  logic         arm = 1'b0, stop = 1'b0, rd = 1'b0;

  logic [50:0] a_dout, b_dout;
  logic        a_dv, b_dv, a_empty, b_empty, a_full, b_full;
  logic [3:0]  a_cnt, b_cnt;
  logic [1:0]  a_st, b_st;
  logic [39:0] a_drop, b_drop;
  logic        a_ovf, b_ovf;

  logic [15:0] tb_ts;
  logic [15:0] ets;
  logic [15:0] tsv [3];
  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) tb_ts <= '0;
    else       tb_ts <= tb_ts + 16'd1;

  trace_collector #(.N_SRC(5), .TRw(32), .TSw(16), .TB_DEPTH(8),
    .ARB_TYPE("FIXED"), .BUF_MODE("STOP")) u_a (
    .clk(clk), .reset(reset), .trace_in(trace_in),
    .trigger_in(trigger_in), .src_en(src_en), .arm(arm),
    .stop(stop), .rd(rd), .dout(a_dout), .dout_valid(a_dv),
    .empty(a_empty), .full(a_full), .count(a_cnt), .state(a_st),
    .drop_cnt_all(a_drop), .overflow(a_ovf));

  trace_collector #(.N_SRC(5), .TRw(32), .TSw(16), .TB_DEPTH(8),
    .ARB_TYPE("RRA"), .BUF_MODE("WRAP")) u_b (
    .clk(clk), .reset(reset), .trace_in(trace_in),
    .trigger_in(trigger_in), .src_en(src_en), .arm(arm),
    .stop(stop), .rd(rd), .dout(b_dout), .dout_valid(b_dv),
    .empty(b_empty), .full(b_full), .count(b_cnt), .state(b_st),
    .drop_cnt_all(b_drop), .overflow(b_ovf));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [50:0] mk(input int s, input logic [15:0] t,
                                     input logic [31:0] d);
    logic [2:0] s3;
    s3 = s[2:0];
    return {s3, t, d};
  endfunction

  task automatic pulse_stop_arm();
    stop = 1'b1; tick(); stop = 1'b0;
    arm  = 1'b1; tick(); arm  = 1'b0;
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_state", 64'(a_st), 64'd0);
    chk("rst_count", 64'(a_cnt), 64'd0);
    chk("rst_empty", 64'(a_empty), 64'd1);
    chk("rst_full", 64'(a_full), 64'd0);
    chk("rst_dout", 64'(a_dout), 64'd0);
    chk("rst_dv", 64'(a_dv), 64'd0);
    chk("rst_drop", 64'(a_drop), 64'd0);
    chk("rst_ovf", 64'(b_ovf), 64'd0);

    arm = 1'b1; tick(); arm = 1'b0;
    chk("arm_state_a", 64'(a_st), 64'd1);
    chk("arm_state_b", 64'(b_st), 64'd1);

    // simultaneous burst on all five sources
    for (int i = 0; i < 5; i++) trace_in[i*32 +: 32] = 32'hA0 + 32'(i);
    trigger_in = 5'b11111;
    ets = tb_ts;
    tick();
    trigger_in = '0;
    chk("burst_cnt0", 64'(a_cnt), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("burst_cnt_a", 64'(a_cnt), 64'(i + 1));
      chk("burst_cnt_b", 64'(b_cnt), 64'(i + 1));
    end
    chk("burst_drop_a", 64'(a_drop), 64'd0);
    chk("burst_drop_b", 64'(b_drop), 64'd0);
    rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("burst_dv", 64'(a_dv), 64'd1);
      chk("burst_dout_a", 64'(a_dout), 64'(mk(i, ets, 32'hA0 + 32'(i))));
      chk("burst_dout_b", 64'(b_dout), 64'(mk(i, ets, 32'hA0 + 32'(i))));
    end
    tick();
    rd = 1'b0;
    chk("rd_empty_dv", 64'(a_dv), 64'd0);
    chk("rd_empty_hold", 64'(a_dout), 64'(mk(4, ets, 32'hA4)));
    chk("rd_empty_flag", 64'(a_empty), 64'd1);

    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_state", 64'(a_st), 64'd2);
    arm = 1'b1; stop = 1'b1; tick(); arm = 1'b0; stop = 1'b0;
    chk("arm_wins", 64'(a_st), 64'd1);

    // sources 1 and 3 trigger together for 7 cycles
    for (int k = 1; k <= 7; k++) begin
      trace_in[32 +: 32] = 32'h100 + 32'(k);
      trace_in[96 +: 32] = 32'h300 + 32'(k);
      trigger_in = 5'b01010;
      tick();
    end
    trigger_in = '0;
    tick(); tick(); tick();
    chk("rr_cnt_b", 64'(b_cnt), 64'd8);
    chk("rr_full_b", 64'(b_full), 64'd1);
    chk("rr_ovf_b", 64'(b_ovf), 64'd0);
    chk("rr_drop1_b", 64'(b_drop[15:8]), 64'd3);
    chk("rr_drop3_b", 64'(b_drop[31:24]), 64'd3);
    chk("fx_cnt_a", 64'(a_cnt), 64'd8);
    chk("fx_drop1_a", 64'(a_drop[15:8]), 64'd0);
    chk("fx_drop3_a", 64'(a_drop[31:24]), 64'd6);
    rd = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("rr_src_b", 64'(b_dout[50:48]), (j % 2 == 1) ? 64'd3 : 64'd1);
      chk("fx_src_a", 64'(a_dout[50:48]), (j == 7) ? 64'd3 : 64'd1);
    end
    rd = 1'b0;

    // twelve spaced single triggers on source 0
    pulse_stop_arm();
    trace_in = '0;
    for (int k = 1; k <= 12; k++) begin
      trace_in[31:0] = 32'(k);
      trigger_in = 5'b00001;
      tick();
      trigger_in = '0;
      tick();
    end
    chk("stop_cnt_a", 64'(a_cnt), 64'd8);
    chk("stop_full_a", 64'(a_full), 64'd1);
    chk("stop_drop_a", 64'(a_drop[7:0]), 64'd3);
    chk("stop_ovf_a", 64'(a_ovf), 64'd0);
    chk("wrap_cnt_b", 64'(b_cnt), 64'd8);
    chk("wrap_ovf_b", 64'(b_ovf), 64'd1);
    chk("wrap_drop_b", 64'(b_drop), 64'd0);
    rd = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("stop_data_a", 64'(a_dout[31:0]), 64'(j + 1));
      chk("wrap_data_b", 64'(b_dout[31:0]), 64'(j + 5));
    end
    rd = 1'b0;
    pulse_stop_arm();
    chk("rearm_drop_a", 64'(a_drop), 64'd0);
    chk("rearm_ovf_b", 64'(b_ovf), 64'd0);
    chk("rearm_cnt_a", 64'(a_cnt), 64'd0);

    // three entries, stop, then four reads
    for (int k = 0; k < 3; k++) begin
      trace_in[64 +: 32] = 32'h21 + 32'(k);
      trigger_in = 5'b00100;
      tsv[k] = tb_ts;
      tick();
      trigger_in = '0;
      tick();
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("rs_state", 64'(a_st), 64'd2);
    chk("rs_cnt", 64'(a_cnt), 64'd3);
    rd = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("rs_dv", 64'(a_dv), (j < 3) ? 64'd1 : 64'd0);
      if (j < 3)
        chk("rs_dout", 64'(a_dout), 64'(mk(2, tsv[j], 32'h21 + 32'(j))));
    end
    rd = 1'b0;
    chk("rs_empty", 64'(a_empty), 64'd1);
    arm = 1'b1; tick(); arm = 1'b0;
    chk("rs_arm_state", 64'(a_st), 64'd1);
    chk("rs_arm_cnt", 64'(a_cnt), 64'd0);

    // build count=5, ignored arm, then asynchronous reset
    for (int k = 0; k < 5; k++) begin
      trigger_in = 5'b00001;
      tick();
      trigger_in = '0;
      tick();
    end
    chk("mid_cnt", 64'(a_cnt), 64'd5);
    arm = 1'b1; tick(); arm = 1'b0;
    chk("arm_in_run", 64'(a_cnt), 64'd5);
    #2 reset = 1'b1;
    #1;
    chk("ar_state", 64'(a_st), 64'd0);
    chk("ar_count", 64'(a_cnt), 64'd0);
    chk("ar_empty", 64'(a_empty), 64'd1);
    chk("ar_full", 64'(b_full), 64'd0);
    chk("ar_dout", 64'(a_dout), 64'd0);
    chk("ar_dv", 64'(a_dv), 64'd0);
    chk("ar_drop", 64'(a_drop), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
